// File: rtl/crc_frame_loader.sv
`default_nettype none
// ============================================================================
// Module   : crc_frame_loader
// Purpose  : Buffers one byte-stream frame, serves it to crc_system and
//            reports a per-frame CRC verdict. Optional: CRC_LOADER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module crc_frame_loader #(
  parameter int ADDR_W    = 10,
  parameter int FRAME_LEN = 1024,
  parameter int TIMEOUT   = 4096
) (
  input  logic              clk50m,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              crc_start,
  output logic [15:0]       crc_out_target,
  input  logic              crc_rdy,
  input  logic              crc_ok,
  output logic              res_valid,
  output logic              res_ok,
  output logic              res_timeout,
  output logic              frame_err
);

  localparam logic [2:0] c_st_load   = 3'd0;
  localparam logic [2:0] c_st_tgt_lo = 3'd1;
  localparam logic [2:0] c_st_tgt_hi = 3'd2;
  localparam logic [2:0] c_st_start  = 3'd3;
  localparam logic [2:0] c_st_wait   = 3'd4;
  localparam logic [2:0] c_st_result = 3'd5;
  localparam logic [2:0] c_st_drop   = 3'd6;

  localparam logic [ADDR_W:0] c_last_idx = (ADDR_W + 1)'(FRAME_LEN - 1);

  if (FRAME_LEN < 1 || FRAME_LEN > (1 << ADDR_W) || TIMEOUT < 1) begin : g_bad_params
    $error("crc_frame_loader: illegal parameter combination");
  end

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic [ADDR_W:0]   r_cnt;
  logic [7:0]        r_mem [0:(1 << ADDR_W)-1];
  logic [7:0]        r_mem_data;
  logic [15:0]       r_target;
  logic              r_in_ready;
  logic              r_rdy_q;
  logic              r_crc_start;
  logic              r_res_valid;
  logic              r_res_ok;
  logic              r_frame_err;
  logic              w_accept;
  logic              w_rdy_rise;
  logic              w_done;
  logic              w_to_flag;
  logic              w_err;
  logic              w_wr;
  logic              w_ready_next;

  assign w_accept   = in_valid & r_in_ready;
  assign w_rdy_rise = crc_rdy & ~r_rdy_q;
  assign w_wr       = w_accept & ~in_last & (r_state == c_st_load);
  assign w_err      = w_accept & in_last &
                      ((r_state == c_st_load) | (r_state == c_st_tgt_lo) | (r_state == c_st_drop));

`ifdef CRC_LOADER_TIMEOUT_EN
  localparam int c_to_w = $clog2(TIMEOUT + 1);

  logic [c_to_w-1:0] r_wait_cnt;
  logic              r_timed_out;
  logic              r_res_timeout;
  logic              w_expire;

  assign w_expire  = (r_wait_cnt == c_to_w'(TIMEOUT - 1));
  assign w_done    = w_rdy_rise | w_expire;
  assign w_to_flag = r_timed_out;

  // A real rising edge in the expiry cycle takes priority over the timeout.
  always_ff @(posedge clk50m) begin
    if (rst) begin
      r_wait_cnt    <= '0;
      r_timed_out   <= 1'b0;
      r_res_timeout <= 1'b0;
    end else begin
      if (r_state == c_st_wait) begin
        r_wait_cnt  <= r_wait_cnt + 1'b1;
        r_timed_out <= ~w_rdy_rise & w_expire;
      end else begin
        r_wait_cnt  <= '0;
      end
      if (r_state == c_st_result) r_res_timeout <= r_timed_out;
    end
  end

  assign res_timeout = r_res_timeout;
`else
  assign w_done      = w_rdy_rise;
  assign w_to_flag   = 1'b0;
  assign res_timeout = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_load:   if (w_accept && !in_last && r_cnt == c_last_idx) w_next = c_st_tgt_lo;
      c_st_tgt_lo: if (w_accept) w_next = in_last ? c_st_load : c_st_tgt_hi;
      c_st_tgt_hi: if (w_accept) w_next = in_last ? c_st_start : c_st_drop;
      c_st_start:  w_next = c_st_wait;
      c_st_wait:   if (w_done) w_next = c_st_result;
      c_st_result: w_next = c_st_load;
      c_st_drop:   if (w_accept && in_last) w_next = c_st_load;
      default:     w_next = c_st_load;
    endcase
  end

  assign w_ready_next = (w_next == c_st_load) | (w_next == c_st_tgt_lo) |
                        (w_next == c_st_tgt_hi) | (w_next == c_st_drop);

  always_ff @(posedge clk50m) begin
    if (rst) begin
      r_state     <= c_st_load;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_rdy_q     <= 1'b0;
      r_crc_start <= 1'b0;
      r_target    <= '0;
      r_res_valid <= 1'b0;
      r_res_ok    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_in_ready  <= w_ready_next;
      r_rdy_q     <= crc_rdy;
      r_crc_start <= (w_next == c_st_start);
      r_res_valid <= (r_state == c_st_result);
      r_frame_err <= w_err;
      if (r_state == c_st_load && w_accept)
        r_cnt <= (in_last || r_cnt == c_last_idx) ? '0 : r_cnt + 1'b1;
      else if (r_state != c_st_load)
        r_cnt <= '0;
      if (w_accept && !in_last && r_state == c_st_tgt_lo) r_target[7:0]  <= in_data;
      if (w_accept && r_state == c_st_tgt_hi)             r_target[15:8] <= in_data;
      if (r_state == c_st_result) r_res_ok <= crc_ok & ~w_to_flag;
    end
  end

  // Payload storage has no reset; only the read-data register is cleared.
  always_ff @(posedge clk50m) begin
    if (w_wr) r_mem[r_cnt[ADDR_W-1:0]] <= in_data;
  end

  always_ff @(posedge clk50m) begin
    if (rst) r_mem_data <= '0;
    else     r_mem_data <= r_mem[mem_addr];
  end

  assign in_ready       = r_in_ready;
  assign mem_data       = r_mem_data;
  assign crc_start      = r_crc_start;
  assign crc_out_target = r_target;
  assign res_valid      = r_res_valid;
  assign res_ok         = r_res_ok;
  assign frame_err      = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_crc_frame_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_crc_frame_loader
// Purpose  : Self-checking bench for crc_frame_loader with a CRC-16/USB
//            downstream model. Timeout case only with CRC_LOADER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_crc_frame_loader;

  localparam int ADDR_W    = 4;
  localparam int FRAME_LEN = 9;
  localparam int TIMEOUT   = 16;

  logic              clk50m = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_addr = '0;
  logic [7:0]        mem_data;
  logic              crc_start;
  logic [15:0]       crc_out_target;
  logic              crc_rdy = 1'b0;
  logic              crc_ok = 1'b0;
  logic              res_valid;
  logic              res_ok;
  logic              res_timeout;
  logic              frame_err;

  crc_frame_loader #(
    .ADDR_W    (ADDR_W),
    .FRAME_LEN (FRAME_LEN),
    .TIMEOUT   (TIMEOUT)
  ) u_dut (
    .clk50m         (clk50m),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_last        (in_last),
    .in_ready       (in_ready),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .crc_start      (crc_start),
    .crc_out_target (crc_out_target),
    .crc_rdy        (crc_rdy),
    .crc_ok         (crc_ok),
    .res_valid      (res_valid),
    .res_ok         (res_ok),
    .res_timeout    (res_timeout),
    .frame_err      (frame_err)
  );

  always #10 clk50m = ~clk50m;

  int n_tests = 0;
  int n_fail  = 0;
  int n_start_seen = 0;
  int n_err_seen   = 0;
  int n_start_exp  = 0;
  int n_err_exp    = 0;
  logic [7:0] g_frame[$];

  always @(negedge clk50m) begin
    if (crc_start === 1'b1) n_start_seen++;
    if (frame_err === 1'b1) n_err_seen++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk50m);
    #1;
  endtask

  // Reflected CRC-16/USB step: poly 0x8005, init 0xFFFF, final xor 0xFFFF.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  function automatic logic [15:0] frame_crc();
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < FRAME_LEN; i++) c = crc_step(c, g_frame[i]);
    return ~c;
  endfunction

  task automatic send_frame();
    int guard;
    for (int i = 0; i < g_frame.size(); i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
      end
      in_valid = 1'b1;
      in_data  = g_frame[i];
      in_last  = (i == g_frame.size() - 1);
      guard = 0;
      while (in_ready !== 1'b1 && guard < 100) begin
        tick();
        guard++;
      end
      if (guard >= 100) check_val("in_ready_wait", in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic serve(input bit exp_ok);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int a = 0; a < FRAME_LEN; a++) begin
      mem_addr = ADDR_W'(a);
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      in_last  = 1'($urandom_range(0, 1));
      tick();
      check_val("mem_data", mem_data, g_frame[a]);
      check_val("in_ready_busy", in_ready, 0);
      check_val("res_valid_early", res_valid, 0);
      c = crc_step(c, mem_data);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (crc_rdy) begin
      crc_rdy = 1'b0;
      tick();
      check_val("res_valid_stale", res_valid, 0);
    end
    crc_rdy = 1'b1;
    crc_ok  = ((~c) == crc_out_target);
    tick();
    check_val("res_valid_r1", res_valid, 0);
    tick();
    check_val("res_valid", res_valid, 1);
    check_val("res_ok", res_ok, exp_ok);
    check_val("res_timeout", res_timeout, 0);
    check_val("in_ready_after", in_ready, 1);
    crc_ok = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 1) == 1) crc_rdy = 1'b0;
    tick();
    check_val("res_valid_pulse", res_valid, 0);
    check_val("res_ok_hold", res_ok, exp_ok);
  endtask

  // Expected outcome follows only from where in_last lands in the byte list.
  task automatic do_frame(input bit stale);
    bit runs;
    logic [15:0] tgt;
    runs = (g_frame.size() == FRAME_LEN + 2);
    if (stale) crc_rdy = 1'b1;
    send_frame();
    check_val("frame_err", frame_err, !runs);
    check_val("crc_start", crc_start, runs);
    if (runs) begin
      n_start_exp++;
      tgt = {g_frame[FRAME_LEN+1], g_frame[FRAME_LEN]};
      check_val("target", crc_out_target, tgt);
      serve(frame_crc() == tgt);
    end else begin
      n_err_exp++;
    end
  endtask

  task automatic make_good(input bit corrupt);
    logic [15:0] c;
    g_frame = {};
    for (int i = 0; i < FRAME_LEN; i++) g_frame.push_back(8'($urandom));
    c = frame_crc();
    if (corrupt) c = c ^ 16'($urandom_range(1, 65535));
    g_frame.push_back(c[7:0]);
    g_frame.push_back(c[15:8]);
  endtask

  task automatic make_random();
    int kind;
    int len;
    kind = $urandom_range(0, 3);
    if (kind < 2) begin
      make_good(kind == 1);
    end else begin
      len = (kind == 2) ? $urandom_range(1, FRAME_LEN + 1) : $urandom_range(FRAME_LEN + 3, FRAME_LEN + 6);
      g_frame = {};
      for (int i = 0; i < len; i++) g_frame.push_back(8'($urandom));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_in_ready"}, in_ready, 0);
    check_val({tag, "_mem_data"}, mem_data, 0);
    check_val({tag, "_crc_start"}, crc_start, 0);
    check_val({tag, "_target"}, crc_out_target, 0);
    check_val({tag, "_res_valid"}, res_valid, 0);
    check_val({tag, "_res_ok"}, res_ok, 0);
    check_val({tag, "_res_timeout"}, res_timeout, 0);
    check_val({tag, "_frame_err"}, frame_err, 0);
  endtask

  task automatic reset_in_wait();
    make_good(1'b0);
    crc_rdy = 1'b0;
    send_frame();
    check_val("rst_crc_start", crc_start, 1);
    n_start_exp++;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_all_zero("rst_wait");
    rst = 1'b0;
    tick();
    check_val("rst_in_ready", in_ready, 1);
    crc_rdy = 1'b1;
    repeat (3) tick();
    check_val("rst_no_result", res_valid, 0);
    crc_rdy = 1'b0;
  endtask

`ifdef CRC_LOADER_TIMEOUT_EN
  task automatic timeout_case();
    int n;
    make_good(1'b0);
    crc_rdy = 1'b0;
    send_frame();
    check_val("to_crc_start", crc_start, 1);
    n_start_exp++;
    n = 0;
    while (res_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check_val("to_latency", n, TIMEOUT + 2);
    check_val("to_res_timeout", res_timeout, 1);
    check_val("to_res_ok", res_ok, 0);
    check_val("to_in_ready", in_ready, 1);
  endtask
`endif

  initial begin
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check_val("ready_after_reset", in_ready, 1);

    g_frame = {};
    for (int i = 0; i < FRAME_LEN; i++) g_frame.push_back(8'h31 + 8'(i));
    g_frame.push_back(8'hC8);
    g_frame.push_back(8'hB4);
    do_frame(1'b0);

    g_frame[FRAME_LEN]   = 8'h00;
    g_frame[FRAME_LEN+1] = 8'h00;
    do_frame(1'b0);

    g_frame = {8'h31, 8'h32, 8'h33};
    do_frame(1'b0);
    make_good(1'b0);
    do_frame(1'b0);

    g_frame = {};
    for (int i = 0; i < FRAME_LEN + 4; i++) g_frame.push_back(8'($urandom));
    do_frame(1'b0);

    make_good(1'b0);
    do_frame(1'b1);

    reset_in_wait();
    make_good(1'b0);
    do_frame(1'b0);

`ifdef CRC_LOADER_TIMEOUT_EN
    timeout_case();
    make_good(1'b0);
    do_frame(1'b0);
`endif

    for (int k = 0; k < 40; k++) begin
      make_random();
      do_frame(1'($urandom_range(0, 1)));
    end

    repeat (3) tick();
    check_val("start_count", n_start_seen, n_start_exp);
    check_val("err_count", n_err_seen, n_err_exp);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
